// File: rtl/pattern_input_controller.sv
// Front-panel button front end for the LED pattern generator.
// Sync + debounce + edge detect per button, pattern stepping with auto-repeat.
module pattern_input_controller #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter int         REPEAT_DELAY    = 8,
   parameter int         REPEAT_PERIOD   = 2,
   parameter logic [2:0] RESET_PAT       = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_speed,
   input  logic       btn_pause,
   output logic [2:0] pat_sel,
   output logic       speed_sel,
   output logic       pause,
   output logic       pat_step
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] RD_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } state_t;

   // Bit order: 0 next, 1 prev, 2 speed, 3 pause
   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    deb;
   logic [3:0]    deb_q;
   logic [3:0]    press;
   logic [DW-1:0] db_cnt [4];

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          dir_up;
   logic          held;
   logic          both;
   logic [2:0]    pat_up;
   logic [2:0]    pat_dn;

   assign raw    = {btn_pause, btn_speed, btn_prev, btn_next};
   assign press  = deb & ~deb_q;
   assign both   = deb[0] & deb[1];
   assign held   = dir_up ? deb[0] : deb[1];
   assign pat_up = pat_sel + 3'd1;
   assign pat_dn = pat_sel - 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         dir_up    <= 1'b0;
         pat_sel   <= RESET_PAT;
         speed_sel <= 1'b0;
         pause     <= 1'b0;
         pat_step  <= 1'b0;
      end else begin
         pat_step <= 1'b0;
         if (!ena) begin
            // Disabled: drop events so a held button needs a fresh press
            state    <= IDLE;
            hold_cnt <= '0;
         end else begin
            if (press[2]) speed_sel <= ~speed_sel;
            if (press[3]) pause <= ~pause;
            unique case (state)
               IDLE: begin
                  if ((press[0] ^ press[1]) && !both) begin
                     pat_sel  <= press[0] ? pat_up : pat_dn;
                     pat_step <= 1'b1;
                     dir_up   <= press[0];
                     state    <= HOLD;
                     hold_cnt <= '0;
                  end
               end
               HOLD: begin
                  if (both || !held) begin
                     state <= IDLE;
                  end else if (hold_cnt == RD_LAST) begin
                     pat_sel  <= dir_up ? pat_up : pat_dn;
                     pat_step <= 1'b1;
                     state    <= REPEAT;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (both || !held) begin
                     state <= IDLE;
                  end else if (hold_cnt == RP_LAST) begin
                     pat_sel  <= dir_up ? pat_up : pat_dn;
                     pat_step <= 1'b1;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pattern_input_controller.sv
// Bench for pattern_input_controller: table-driven button presses,
// pat_step events checked against a queue of expected steps.
module tb_pattern_input_controller;

   localparam int D    = 4;
   localparam int RDLY = 8;
   localparam int RPER = 2;
   localparam int GAP  = 10;

   localparam logic [3:0] NX = 4'b0001;
   localparam logic [3:0] PV = 4'b0010;
   localparam logic [3:0] SP = 4'b0100;
   localparam logic [3:0] PZ = 4'b1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       btn_next;
   logic       btn_prev;
   logic       btn_speed;
   logic       btn_pause;
   logic [2:0] pat_sel;
   logic       speed_sel;
   logic       pause;
   logic       pat_step;

   typedef struct {
      int         cyc;
      logic [2:0] pat;
   } step_t;

   typedef struct {
      logic [3:0] btn;
      int         hold;
      logic [2:0] exp_pat;
      logic       exp_speed;
      logic       exp_pause;
   } vec_t;

   step_t      sbq[$];
   step_t      mon_e;
   vec_t       vt[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic [2:0] sb_pat;

   pattern_input_controller #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RDLY),
      .REPEAT_PERIOD(RPER),
      .RESET_PAT(3'd0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .btn_speed(btn_speed),
      .btn_pause(btn_pause),
      .pat_sel(pat_sel),
      .speed_sel(speed_sel),
      .pause(pause),
      .pat_step(pat_step)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] m);
      btn_next  = m[0];
      btn_prev  = m[1];
      btn_speed = m[2];
      btn_pause = m[3];
   endtask

   // Called at a negedge: the next posedge is edge 0 of the press.
   // A step is expected at edge D+2, then after RDLY, then every RPER,
   // while the debounced level is still high (up to edge hold+D+1).
   task automatic press(input logic [3:0] m, input int hold);
      int c;
      int t;
      c = cyc;
      drive(m);
      if ((m[0] ^ m[1]) && hold >= D) begin
         t = c + D + 3;
         while (t <= c + hold + D + 2) begin
            sb_pat = m[0] ? sb_pat + 3'd1 : sb_pat - 3'd1;
            sbq.push_back('{t, sb_pat});
            t = (t == c + D + 3) ? t + RDLY : t + RPER;
         end
      end
      repeat (hold) @(negedge clk);
      drive(4'b0000);
      repeat (GAP) @(negedge clk);
   endtask

   task automatic add(input logic [3:0] m, input int h, input logic [2:0] p,
                      input logic s, input logic z);
      vt.push_back('{m, h, p, s, z});
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      sb_pat = 3'd0;
      drive(NX);

      add(PV, 6, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) add(NX, 3, 3'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) add(NX, 6, 3'(i), 1'b0, 1'b0);
      add(PV, 6, 3'd7, 1'b0, 1'b0);
      add(NX, 24, 3'd0, 1'b0, 1'b0);
      add(PV, 16, 3'd3, 1'b0, 1'b0);
      add(NX | PV, 6, 3'd3, 1'b0, 1'b0);
      add(PZ, 6, 3'd3, 1'b0, 1'b1);
      add(PZ, 6, 3'd3, 1'b0, 1'b0);
      add(SP, 6, 3'd3, 1'b1, 1'b0);
      add(NX | PV | SP, 6, 3'd3, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pat", pat_sel, 0);
      chk("rst_speed", speed_sel, 0);
      chk("rst_pause", pause, 0);
      chk("rst_step", pat_step, 0);

      fork
         forever begin
            @(negedge clk);
            if (pat_step === 1'b1) begin
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_step cyc=%0d pat_sel=%0d",
                           cyc, pat_sel);
               end else begin
                  mon_e = sbq.pop_front();
                  chk("step_cyc", cyc, mon_e.cyc);
                  chk("step_pat", pat_sel, mon_e.pat);
               end
            end
         end
      join_none

      // next still held through reset: must debounce from scratch
      rst = 1'b0;
      press(NX, 6);
      chk("held_rst_pat", pat_sel, 1);
      chk("held_rst_sb", sbq.size(), 0);

      for (int i = 0; i < vt.size(); i++) begin
         press(vt[i].btn, vt[i].hold);
         chk($sformatf("v%0d_pat", i), pat_sel, vt[i].exp_pat);
         chk($sformatf("v%0d_speed", i), speed_sel, vt[i].exp_speed);
         chk($sformatf("v%0d_pause", i), pause, vt[i].exp_pause);
         chk($sformatf("v%0d_sb", i), sbq.size(), 0);
      end

      // Press while disabled, re-enable while still held
      ena = 1'b0;
      drive(SP | NX);
      repeat (12) @(negedge clk);
      ena = 1'b1;
      repeat (8) @(negedge clk);
      chk("ena_held_speed", speed_sel, 0);
      chk("ena_held_pat", pat_sel, 3);
      drive(4'b0000);
      repeat (GAP) @(negedge clk);
      chk("ena_rel_speed", speed_sel, 0);
      chk("ena_rel_pat", pat_sel, 3);
      press(SP, 6);
      chk("ena_repress_speed", speed_sel, 1);
      press(NX, 6);
      chk("ena_repress_pat", pat_sel, 4);
      chk("final_sb", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
